serial_subtractor: RTL

Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock. It is the inverse-direction companion of the mux-based full-adder datapath. It uses a full-subtractor cell built from a 4:1 mux and a registered borrow flip-flop. Operands are captured on a start handshake; the result and final borrow are presented with a one-cycle done pulse. It sits in the lab ALU datapath beside the serial adder.

---
 rtl/sub_pkg.sv | 36 +++
 rtl/fs_mux_cell.sv | 19 +
 rtl/serial_subtractor.sv | 87 ++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the full-subtractor mux truth tables. No ports (package).
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // What each leg of a cell mux carries.
   typedef enum logic [1:0] {
      LEG_BIN,
      LEG_NBIN,
      LEG_ZERO,
      LEG_ONE
   } leg_t;

   // Mux tables indexed by the select {a,b}: 00, 01, 10, 11.
   localparam leg_t D_LEG [4] = '{LEG_BIN, LEG_NBIN, LEG_NBIN, LEG_BIN};
   localparam leg_t BO_LEG [4] = '{LEG_BIN, LEG_ONE, LEG_ZERO, LEG_BIN};

   function automatic logic leg_val(input leg_t leg, input logic bin);
      logic v;
      v = bin;
      case (leg)
         LEG_BIN:  v = bin;
         LEG_NBIN: v = ~bin;
         LEG_ZERO: v = 1'b0;
         LEG_ONE:  v = 1'b1;
         default:  v = bin;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/fs_mux_cell.sv
// Full-subtractor cell built from two 4:1 muxes selected by {a,b}.
// Ports: a, b, bin (borrow in) -> d (difference), bout (borrow out).
module fs_mux_cell
   import sub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic [1:0] sel;

   assign sel  = {a, b};
   assign d    = leg_val(D_LEG[sel], bin);
   assign bout = leg_val(BO_LEG[sel], bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, with a done pulse.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done,
//        diff (a - b mod 2^WIDTH), borrow_out (1 iff a < b).
module serial_subtractor
   import sub_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic             bff;
   logic [CNT_W-1:0] cnt;
   logic             d;
   logic             bo;
   logic             last;

   fs_mux_cell u_cell (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (bff),
      .d    (d),
      .bout (bo)
   );

   assign last = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sa         <= '0;
         sb         <= '0;
         sr         <= '0;
         bff        <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            sa  <= a;
            sb  <= b;
            bff <= 1'b0;
            cnt <= '0;
         end else if (state == RUN) begin
            sr  <= {d, sr[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            bff <= bo;
            cnt <= cnt + CNT_W'(1);
            // Results move only here, so they never glitch mid-RUN.
            if (last) begin
               diff       <= {d, sr[WIDTH-1:1]};
               borrow_out <= bo;
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
